// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer: picks the PC register load value/enable from sequential, redirect and exception sources.
// Optional misaligned-target trap enabled by defining PC_SEQ_ALIGN_CHECK_EN.
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_cur_i,
    input  logic        stall_i,
    input  logic        br_req_i,
    input  logic [31:0] br_target_i,
    input  logic        eret_req_i,
    input  logic [31:0] epc_i,
    input  logic        exc_req_i,
    output logic [31:0] pc_next_o,
    output logic        pc_en_o,
    output logic        flush_o,
    output logic        pend_o,
    output logic        adel_fetch_o
);

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_PEND  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic [31:0] pc_raw;
    logic        redir_req;
    logic [31:0] redir_tgt;
    logic        redir_bad;

    // ERET outranks a branch arriving in the same cycle.
    assign redir_req = eret_req_i | br_req_i;
    assign redir_tgt = eret_req_i ? epc_i : br_target_i;

`ifdef PC_SEQ_ALIGN_CHECK_EN
    assign redir_bad = redir_req && (redir_tgt[1:0] != 2'b00);
`else
    assign redir_bad = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pend_target_d = pend_target_q;
        pc_raw        = RESET_PC;
        pc_en_o       = 1'b0;
        flush_o       = 1'b0;
        pend_o        = 1'b0;
        adel_fetch_o  = 1'b0;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN, S_PEND: begin
                pend_o = (state_q == S_PEND);
                if (exc_req_i || redir_bad) begin
                    // Exception entry ignores stall: the faulting fetch must not proceed.
                    pc_raw       = EXC_VEC;
                    pc_en_o      = 1'b1;
                    flush_o      = 1'b1;
                    adel_fetch_o = redir_bad && !exc_req_i;
                    state_d      = S_FLUSH;
                end else if (redir_req && !stall_i) begin
                    pc_raw  = redir_tgt;
                    pc_en_o = 1'b1;
                    state_d = S_RUN;
                end else if (redir_req) begin
                    pc_raw        = redir_tgt;
                    pend_target_d = redir_tgt;
                    state_d       = S_PEND;
                end else if (state_q == S_PEND) begin
                    pc_raw  = pend_target_q;
                    pc_en_o = !stall_i;
                    state_d = stall_i ? S_PEND : S_RUN;
                end else begin
                    pc_raw  = pc_cur_i + 32'd4;
                    pc_en_o = !stall_i;
                end
            end
            S_FLUSH: begin
                pc_raw  = EXC_VEC;
                flush_o = 1'b1;
                state_d = S_RUN;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign pc_next_o = pc_raw & WORD_MASK;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_BOOT;
            pend_target_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pend_target_q <= pend_target_d;
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: per-cycle reference model check plus directed literal expectations.
module tb_pc_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_cur;
    logic        stall, br_req, eret_req, exc_req;
    logic [31:0] br_target, epc;
    logic [31:0] pc_next;
    logic        pc_en, flush, pend, adel_fetch;

    int checks = 0;
    int errors = 0;

`ifdef PC_SEQ_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    pc_seq_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pc_cur_i     (pc_cur),
        .stall_i      (stall),
        .br_req_i     (br_req),
        .br_target_i  (br_target),
        .eret_req_i   (eret_req),
        .epc_i        (epc),
        .exc_req_i    (exc_req),
        .pc_next_o    (pc_next),
        .pc_en_o      (pc_en),
        .flush_o      (flush),
        .pend_o       (pend),
        .adel_fetch_o (adel_fetch)
    );

    always #5 clk = ~clk;

    // The PC register this sequencer feeds.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pc_cur <= 32'h0000_3000;
        else if (pc_en) pc_cur <= pc_next;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: just "booting", "flushing" and an optional held target.
    bit          m_boot, m_flush, m_has;
    logic [31:0] m_tgt;
    bit          n_boot, n_flush, n_has;
    logic [31:0] n_tgt;

    always @(negedge clk) begin
        logic [31:0] e_pc, tgt;
        bit e_pc_valid, e_en, e_flush, e_pend, e_adel, req, bad;
        if (!rst_n) begin
            n_boot = 1; n_flush = 0; n_has = 0; n_tgt = 0;
        end else begin
            n_boot = 0; n_flush = 0; n_has = m_has; n_tgt = m_tgt;
            e_pc_valid = 1; e_pc = 0; e_en = 0; e_flush = 0; e_pend = 0; e_adel = 0;
            req = eret_req || br_req;
            tgt = eret_req ? epc : br_target;
            bad = ALIGN_EN && req && (tgt % 4 != 0);
            if (m_boot) begin
                e_pc = 32'h3000;
            end else if (m_flush) begin
                e_pc = 32'h4180; e_flush = 1;
            end else begin
                e_pend = m_has;
                if (exc_req || bad) begin
                    e_pc = 32'h4180; e_en = 1; e_flush = 1; e_adel = bad && !exc_req;
                    n_flush = 1; n_has = 0;
                end else if (req && !stall) begin
                    e_pc = tgt - (tgt % 4); e_en = 1; n_has = 0;
                end else if (req) begin
                    e_pc_valid = 0; n_has = 1; n_tgt = tgt;
                end else if (m_has) begin
                    e_pc = m_tgt - (m_tgt % 4); e_en = !stall; n_has = stall;
                end else begin
                    e_pc = (pc_cur - (pc_cur % 4)) + 4; e_en = !stall;
                end
            end
            chk("m_pc_en", {31'b0, pc_en}, {31'b0, e_en});
            chk("m_flush", {31'b0, flush}, {31'b0, e_flush});
            chk("m_pend", {31'b0, pend}, {31'b0, e_pend});
            chk("m_adel", {31'b0, adel_fetch}, {31'b0, e_adel});
            if (e_pc_valid) chk("m_pc_next", pc_next, e_pc);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_boot <= 1; m_flush <= 0; m_has <= 0; m_tgt <= 0;
        end else begin
            m_boot <= n_boot; m_flush <= n_flush; m_has <= n_has; m_tgt <= n_tgt;
        end
    end

    task automatic drive(input bit s, input bit b, input logic [31:0] bt,
                         input bit e, input logic [31:0] ep, input bit x);
        stall = s; br_req = b; br_target = bt; eret_req = e; epc = ep; exc_req = x;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        chk("rst_pc_next", pc_next, 32'h3000);
        chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
        chk("rst_flush_pend", {30'b0, flush, pend}, 32'd0);
        chk("rst_adel", {31'b0, adel_fetch}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Boot cycle ignores an exception request.
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        chk("boot_pc_en", {31'b0, pc_en}, 32'd0);
        chk("boot_pc_next", pc_next, 32'h3000);
        chk("boot_flush", {31'b0, flush}, 32'd0);
        next_cycle(); idle();
        chk("seq_first", pc_next, 32'h3004);
        chk("seq_first_en", {31'b0, pc_en}, 32'd1);

        next_cycle(); drive(0, 1, 32'h3040, 0, 32'h0, 0);
        chk("br_taken", pc_next, 32'h3040);
        next_cycle(); idle();
        chk("after_br", pc_next, 32'h3044);

        // Redirect under stall is held until the stall drops.
        next_cycle(); drive(1, 1, 32'h3100, 0, 32'h0, 0);
        chk("stall_br_en", {31'b0, pc_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle(); drive(1, 0, 32'h0, 0, 32'h0, 0);
            chk("pend_hold", {30'b0, pend, pc_en}, 32'd2);
        end
        next_cycle(); idle();
        chk("pend_release", pc_next, 32'h3100);
        chk("pend_release_en", {31'b0, pc_en}, 32'd1);
        next_cycle(); idle();
        chk("pend_cleared", {31'b0, pend}, 32'd0);
        chk("after_pend", pc_next, 32'h3104);

        // Exception discards a pending redirect.
        next_cycle(); drive(1, 1, 32'h3100, 0, 32'h0, 0);
        next_cycle(); drive(1, 0, 32'h0, 0, 32'h0, 1);
        chk("exc_pend_pc", pc_next, 32'h4180);
        chk("exc_pend_ctl", {30'b0, pc_en, flush}, 32'd3);
        next_cycle(); drive(0, 1, 32'h3500, 0, 32'h0, 0);
        chk("flush_cycle", {30'b0, pc_en, flush}, 32'd1);
        next_cycle(); idle();
        chk("after_flush", pc_next, 32'h4184);

        // Priority: exc > eret > br.
        next_cycle(); drive(0, 1, 32'h3300, 1, 32'h3200, 1);
        chk("prio_exc", pc_next, 32'h4180);
        next_cycle(); idle();
        next_cycle(); drive(0, 1, 32'h3300, 1, 32'h3200, 0);
        chk("prio_eret", pc_next, 32'h3200);

        // Sequential wrap past the top of the address space.
        next_cycle(); drive(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
        next_cycle(); idle();
        chk("pc_wrap", pc_next, 32'h0);

        next_cycle(); drive(0, 1, 32'h3042, 0, 32'h0, 0);
        if (ALIGN_EN) begin
            chk("misalign_pc", pc_next, 32'h4180);
            chk("misalign_adel", {30'b0, adel_fetch, flush}, 32'd3);
        end else begin
            chk("misalign_pc", pc_next, 32'h3040);
            chk("misalign_adel", {30'b0, adel_fetch, flush}, 32'd0);
        end
        next_cycle(); idle();

        // Latest pending redirect wins; eret over br in the same cycle.
        next_cycle(); drive(1, 1, 32'h3300, 0, 32'h0, 0);
        next_cycle(); drive(1, 1, 32'h3500, 1, 32'h3400, 0);
        next_cycle(); idle();
        chk("pend_overwrite", pc_next, 32'h3400);

        // Reset during PEND aborts to boot and drops the target.
        next_cycle(); drive(1, 1, 32'h3600, 0, 32'h0, 0);
        next_cycle(); rst_n = 1'b0; drive(1, 0, 32'h0, 0, 32'h0, 0);
        chk("rst_pend", {30'b0, pend, pc_en}, 32'd0);
        chk("rst_pend_pc", pc_next, 32'h3000);
        next_cycle(); rst_n = 1'b1; idle();
        chk("reboot_en", {31'b0, pc_en}, 32'd0);
        next_cycle(); idle();
        chk("reboot_seq", pc_next, 32'h3004);
        repeat (3) begin
            next_cycle(); idle();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Next-PC sequencer for the pipelined MIPS core.
- Drives the PC register's pc_in/en pair from the current PC, hazard stall, ID-stage branch/jump redirects, M-stage exception requests and ERET.
- Arbitrates concurrent redirect sources by fixed priority.
- Holds redirects that arrive during a stall and issues the IF/ID flush after an exception entry.

Parameters:
- RESET_PC, 32'h0000_3000, fetch address after reset.
- EXC_VEC, 32'h0000_4180, exception/interrupt handler entry address.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pc_cur  in  32  current PC register output.
- stall  in  1  hazard-unit stall request.
- br_req  in  1  single-cycle branch/jump redirect pulse from ID.
- br_target  in  32  redirect target, valid with br_req.
- eret_req  in  1  single-cycle ERET pulse.
- epc  in  32  CP0 EPC, valid with eret_req.
- exc_req  in  1  exception/interrupt entry pulse from M stage.
- pc_next  out  32  value presented to PC register pc_in.
- pc_en  out  1  PC register load enable.
- flush  out  1  IF/ID clear.
- pend  out  1  a redirect is held pending stall release.
- adel_fetch  out  1  misaligned redirect target detected (see Optional Feature).

Behaviour:
- States: BOOT, RUN, PEND, FLUSH. Registers: state, pend_target[31:0].
- Reset (reset==0, async): state=BOOT, pend_target=0. Outputs: pc_next=RESET_PC, pc_en=0, flush=0, pend=0, adel_fetch=0.
- All outputs are combinational from state, pend_target and inputs; zero-cycle latency.
- BOOT: pc_next=RESET_PC, pc_en=0. All requests ignored. Goes to RUN after one cycle.
- RUN, priority exc_req > eret_req > br_req > sequential:
  - exc_req: pc_next=EXC_VEC, pc_en=1 even if stall=1, flush=1. Next state FLUSH.
  - eret_req with stall=0: pc_next=epc, pc_en=1. Stay in RUN.
  - br_req with stall=0: pc_next=br_target, pc_en=1. Stay in RUN.
  - eret_req/br_req with stall=1: pc_en=0, pend_target<=epc or br_target (eret wins if both). Next state PEND.
  - No request: pc_next=pc_cur+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), pc_en=~stall.
- PEND: pend=1, pc_next=pend_target, pc_en=~stall.
  - stall=0: next state RUN. The pending target loads this cycle.
  - New eret_req/br_req while in PEND: overwrites pend_target (latest wins, eret over br in the same cycle). Stays PEND if stall=1. If stall=0, the new target is presented directly this cycle and the state goes to RUN.
  - exc_req: pending redirect discarded. Behaves as the RUN exception case and goes to FLUSH.
- FLUSH: pc_en=0, flush=1, pc_next=EXC_VEC. eret/br/exc requests ignored. Next state RUN.
- Reset asserted in any state aborts immediately to BOOT. A pending target is lost.
- pc_next[1:0] is always forced to 2'b00.

Optional Feature:
- Macro: PC_SEQ_ALIGN_CHECK_EN.
- Defined: a br/eret target with [1:0]!=0 does not redirect. In that cycle adel_fetch=1 and the request is handled exactly as exc_req (pc_next=EXC_VEC, pc_en=1, flush=1, then FLUSH). The same check applies when a misaligned target would be latched into PEND: the redirect is raised as adel_fetch instead of being latched. A real exc_req in the same cycle still wins, and adel_fetch=0 in that case.
- Undefined: adel_fetch tied 0. Low bits are silently cleared and the redirect proceeds.

Test Plan:
- Reset low 3 cycles, then release -> first cycle pc_en=0, pc_next=32'h3000. Next cycle with pc_cur=32'h3000: pc_next=32'h3004, pc_en=1.
- RUN, br_req=1, br_target=32'h3040, stall=0 -> pc_next=32'h3040, pc_en=1 in the same cycle. Next cycle sequential pc_cur+4.
- RUN, stall=1 with br_req pulse (target 32'h3100), stall held 3 more cycles -> pend=1, pc_en=0 throughout. The cycle stall drops: pc_next=32'h3100, pc_en=1. Then pend=0.
- PEND with target 32'h3100, exc_req pulse while stall=1 -> pc_next=32'h4180, pc_en=1, flush=1. Next cycle FLUSH: flush=1, pc_en=0. Then RUN. 32'h3100 is never loaded.
- Same cycle exc_req, eret_req (epc=32'h3200) and br_req -> pc_next=32'h4180. Then same cycle eret_req and br_req in RUN -> pc_next=32'h3200.
- With PC_SEQ_ALIGN_CHECK_EN: br_target=32'h3042 -> adel_fetch=1, pc_next=32'h4180, flush=1. Without it: pc_next=32'h3040, adel_fetch=0.
